// File: rtl/alu_mult_sched.sv
// Round-robin scheduler that shares one external 5x5 multiplier among NREQ requesters.
// Latency: accept cycle N -> rsp_valid at N+2, or at N+1 when either operand is zero.
// Backpressure: holds the response until rsp_ready; new requests are accepted only in IDLE.
module alu_mult_sched #(
    parameter int NREQ = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [5*NREQ-1:0]   req_a,
    input  logic [5*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [4:0]          mul_a,
    output logic [4:0]          mul_b,
    input  logic [9:0]          mul_result,
    output logic                rsp_valid,
    output logic [1:0]          rsp_id,
    output logic [9:0]          rsp_result,
    input  logic                rsp_ready,
    output logic [7:0]          ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  last_grant;
    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic [4:0]  a_arr [NREQ];
    logic [4:0]  b_arr [NREQ];
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;

    // Unpack the per-requester operand slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[5*g +: 5];
        assign b_arr[g] = req_b[5*g +: 5];
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        cand      = last_grant;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == 2'(NREQ - 1)) ? 2'd0 : cand + 2'd1;
            if (req_valid[cand] && !grant_vld) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_a = a_arr[grant_idx];
    assign sel_b = b_arr[grant_idx];

    // Accept strobe is combinational and only ever raised while idle.
    assign req_ready = (state == IDLE && grant_vld) ? (NREQ'(1) << grant_idx) : '0;

    // Scheduler FSM: accept, optional multiply cycle, then hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'(NREQ - 1);
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        last_grant <= grant_idx;
                        rsp_id     <= grant_idx;
                        if (sel_a == 5'd0 || sel_b == 5'd0) begin
                            // Product is known to be zero: skip the multiplier.
                            rsp_result <= '0;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mul_a <= sel_a;
                            mul_b <= sel_b;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rsp_result <= mul_result;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
